// File: rtl/alarm_frame_tx.sv
// alarm_frame_tx: queues alarm events and streams each one as a SYNC/zone/code byte frame over ready/send/data.
// Build option: define ALARM_FRAME_CHECKSUM_EN for 4-byte frames ending with SYNC^zone^code.
module alarm_frame_tx #(
   parameter int         DEPTH = 4,
   parameter logic [7:0] SYNC  = 8'hA5
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       evValid,
   input  logic [7:0] evZone,
   input  logic [7:0] evCode,
   output logic       evReady,
   output logic       dropped,
   input  logic       ready,
   output logic       send,
   output logic [7:0] data,
   output logic       busy
);

   localparam int AW = $clog2(DEPTH);
`ifdef ALARM_FRAME_CHECKSUM_EN
   localparam logic [1:0] LAST_IDX = 2'd3;
`else
   localparam logic [1:0] LAST_IDX = 2'd2;
`endif
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      ACK     = 2'd2,
      WAITRDY = 2'd3
   } state_t;

   state_t        state_reg, state_next;

   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          full, empty, push, pop;

   logic [15:0]   hold_reg;
   logic [1:0]    idx_reg, idx_next;
   logic          send_reg, send_next;
   logic [7:0]    data_reg, data_next;
   logic          dropped_reg;
   logic [7:0]    frame_byte;

   // ------------------------------------------------------------------
   // Event FIFO
   // ------------------------------------------------------------------
   assign full    = (count_reg == FULL_CNT);
   assign empty   = (count_reg == '0);
   assign evReady = !full;
   // A pop on the same edge never frees room for a push: full refuses regardless.
   assign push    = evValid && !full;

   // Storage plus registered read straight into the frame hold register.
   always_ff @(posedge Clock) begin
      if (push)
         mem[wr_ptr_reg] <= {evZone, evCode};
      if (pop)
         hold_reg <= mem[rd_ptr_reg];
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
         dropped_reg <= 1'b0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_ONE;
            2'b01:   count_reg <= count_reg - CNT_ONE;
            default: count_reg <= count_reg;
         endcase
         dropped_reg <= evValid && !evReady;
      end
   end

   // ------------------------------------------------------------------
   // Frame byte selection
   // ------------------------------------------------------------------
   always_comb begin
      frame_byte = 8'h00;
      case (idx_reg)
         2'd0:    frame_byte = SYNC;
         2'd1:    frame_byte = hold_reg[15:8];
         2'd2:    frame_byte = hold_reg[7:0];
`ifdef ALARM_FRAME_CHECKSUM_EN
         2'd3:    frame_byte = SYNC ^ hold_reg[15:8] ^ hold_reg[7:0];
`endif
         default: frame_byte = 8'h00;
      endcase
   end

   // ------------------------------------------------------------------
   // Frame state machine
   // ------------------------------------------------------------------
   always_ff @(posedge Clock) begin
      if (Reset)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (!empty) state_next = ISSUE;
         ISSUE:   if (ready)  state_next = ACK;
         ACK:     if (!ready) state_next = WAITRDY;
         WAITRDY: if (ready)  state_next = (idx_reg == LAST_IDX) ? IDLE : ISSUE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      pop       = 1'b0;
      idx_next  = idx_reg;
      send_next = 1'b0;
      data_next = data_reg;
      case (state_reg)
         IDLE: begin
            if (!empty) begin
               pop      = 1'b1;
               idx_next = 2'd0;
            end
         end
         ISSUE: begin
            if (ready) begin
               send_next = 1'b1;
               data_next = frame_byte;
            end
         end
         WAITRDY: begin
            if (ready && (idx_reg != LAST_IDX))
               idx_next = idx_reg + 2'd1;
         end
         default: begin
         end
      endcase
   end

   // data holds its value until the next ISSUE so the transmitter sees a stable byte.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         idx_reg  <= 2'd0;
         send_reg <= 1'b0;
         data_reg <= 8'h00;
      end else begin
         idx_reg  <= idx_next;
         send_reg <= send_next;
         data_reg <= data_next;
      end
   end

   assign send    = send_reg;
   assign data    = data_reg;
   assign dropped = dropped_reg;
   assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_alarm_frame_tx.sv
// tb_alarm_frame_tx: table-driven, directed and randomized checks of alarm_frame_tx against a frame-level model.
// Follows ALARM_FRAME_CHECKSUM_EN to pick 3- or 4-byte frames.
module tb_alarm_frame_tx;

   localparam int         DEPTH = 4;
   localparam logic [7:0] SYNC  = 8'hA5;
`ifdef ALARM_FRAME_CHECKSUM_EN
   localparam int NB = 4;
`else
   localparam int NB = 3;
`endif

   logic       Clock = 1'b0;
   logic       Reset;
   logic       evValid;
   logic [7:0] evZone;
   logic [7:0] evCode;
   logic       evReady;
   logic       dropped;
   logic       ready;
   logic       send;
   logic [7:0] data;
   logic       busy;

   always #5 Clock = ~Clock;

   alarm_frame_tx #(.DEPTH(DEPTH), .SYNC(SYNC)) dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .evValid (evValid),
      .evZone  (evZone),
      .evCode  (evCode),
      .evReady (evReady),
      .dropped (dropped),
      .ready   (ready),
      .send    (send),
      .data    (data),
      .busy    (busy)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   int         hold_cycles = 0;
   int         busy_cycles = 8;
   logic [7:0] cap_byte;
   logic       prev_send;

   typedef struct {
      logic [7:0] zone;
      logic [7:0] code;
      logic [7:0] csum;
   } vec_t;
   vec_t tbl[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Reference model: a frame is just the ordered byte list built from the event.
   function automatic void expect_frame(input logic [7:0] z, input logic [7:0] c);
      exp_q.push_back(SYNC);
      exp_q.push_back(z);
      exp_q.push_back(c);
      if (NB == 4) exp_q.push_back(SYNC ^ z ^ c);
   endfunction

   task automatic push(input logic [7:0] z, input logic [7:0] c, input logic exp_rdy);
      @(negedge Clock);
      evValid = 1'b1;
      evZone  = z;
      evCode  = c;
      #1;
      chk("evReady", evReady, exp_rdy);
      @(posedge Clock);
      #1;
      evValid = 1'b0;
      chk("dropped", dropped, !exp_rdy);
      $display("push zone=%02h code=%02h evReady=%0b dropped=%0b", z, c, exp_rdy, dropped);
   endtask

   task automatic drain(input string name);
      int t;
      int n;
      t = 0;
      while (((rx_q.size() < exp_q.size()) || busy) && t < 2000) begin
         @(posedge Clock);
         #1;
         t++;
      end
      chk($sformatf("%s_timeout", name), (t < 2000), 1);
      chk($sformatf("%s_bytecount", name), rx_q.size(), exp_q.size());
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_byte%0d", name, i), rx_q[i], exp_q[i]);
      $display("drain %s: %0d bytes received", name, rx_q.size());
      rx_q.delete();
      exp_q.delete();
   endtask

   // Transmitter model: capture on send, optionally keep ready high, then go busy.
   initial begin : tx_model
      forever begin
         @(posedge Clock);
         #1;
         if (send) begin
            cap_byte = data;
            rx_q.push_back(cap_byte);
            for (int i = 0; i < hold_cycles; i++) begin
               @(posedge Clock);
               #1;
               chk("hold_send_low", send, 0);
               chk("hold_data_stable", data, cap_byte);
            end
            ready = 1'b0;
            for (int i = 0; i < busy_cycles; i++) @(posedge Clock);
            #1 ready = 1'b1;
         end
      end
   end

   initial begin : pulse_mon
      prev_send = 1'b0;
      forever begin
         @(posedge Clock);
         #1;
         if (send) chk("send_single_cycle", prev_send, 0);
         prev_send = send;
      end
   end

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [7:0] z, c;
      int t, nb;

      tbl[0] = '{zone: 8'h03, code: 8'h42, csum: 8'hE4};
      tbl[1] = '{zone: 8'h00, code: 8'h00, csum: 8'hA5};
      tbl[2] = '{zone: 8'hFF, code: 8'hFF, csum: 8'hA5};
      tbl[3] = '{zone: 8'h5A, code: 8'h00, csum: 8'hFF};
      tbl[4] = '{zone: 8'h12, code: 8'h34, csum: 8'h83};
      tbl[5] = '{zone: 8'h80, code: 8'h01, csum: 8'h24};

      Reset   = 1'b1;
      evValid = 1'b0;
      evZone  = 8'h00;
      evCode  = 8'h00;
      ready   = 1'b1;
      repeat (2) @(posedge Clock);
      #1;
      chk("rst_send", send, 0);
      chk("rst_data", data, 8'h00);
      chk("rst_busy", busy, 0);
      chk("rst_evReady", evReady, 1);
      chk("rst_dropped", dropped, 0);
      @(negedge Clock);
      Reset = 1'b0;

      // Single event with first-send latency check.
      push(8'h03, 8'h42, 1'b1);
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h03);
      exp_q.push_back(8'h42);
      if (NB == 4) exp_q.push_back(8'hE4);
      @(posedge Clock);
      #1;
      chk("lat_n1_send", send, 0);
      chk("lat_n1_busy", busy, 1);
      @(posedge Clock);
      #1;
      chk("lat_n2_send", send, 1);
      chk("lat_n2_data", data, 8'hA5);
      drain("single");

      // Table-driven frames with hand-computed checksums.
      for (int i = 0; i < 6; i++) begin
         push(tbl[i].zone, tbl[i].code, 1'b1);
         exp_q.push_back(8'hA5);
         exp_q.push_back(tbl[i].zone);
         exp_q.push_back(tbl[i].code);
         if (NB == 4) exp_q.push_back(tbl[i].csum);
         drain($sformatf("table%0d", i));
      end

      // Slow ready: transmitter holds ready high for 5 cycles after each send.
      hold_cycles = 5;
      push(8'h5A, 8'h3C, 1'b1);
      expect_frame(8'h5A, 8'h3C);
      drain("slow_ready");
      hold_cycles = 0;

      // Back-to-back fill: one frame popped, four queued, then a refused push.
      for (int i = 0; i < 5; i++) begin
         push(8'h10 + 8'(i), 8'h20 + 8'(i), 1'b1);
         expect_frame(8'h10 + 8'(i), 8'h20 + 8'(i));
      end
      push(8'hEE, 8'hEE, 1'b0);

      // Full with simultaneous pop: hold evValid through the pop edge.
      @(negedge Clock);
      evValid = 1'b1;
      evZone  = 8'h77;
      evCode  = 8'h88;
      t = 0;
      do begin
         @(posedge Clock);
         #1;
         t++;
      end while (!evReady && t < 1000);
      chk("popedge_timeout", (t < 1000), 1);
      chk("popedge_dropped", dropped, 1);
      @(posedge Clock);
      #1;
      evValid = 1'b0;
      chk("retry_dropped", dropped, 0);
      $display("push zone=77 code=88 accepted after pop edge");
      expect_frame(8'h77, 8'h88);
      drain("b2b_full");

      // Randomized bursts against the frame model.
      for (int b = 0; b < 6; b++) begin
         hold_cycles = $urandom_range(0, 2);
         busy_cycles = $urandom_range(1, 6);
         nb = $urandom_range(1, DEPTH);
         for (int k = 0; k < nb; k++) begin
            z = 8'($urandom);
            c = 8'($urandom);
            push(z, c, 1'b1);
            expect_frame(z, c);
         end
         drain($sformatf("rand%0d", b));
      end
      hold_cycles = 0;

      // Pointer wrap: ten events, one at a time.
      busy_cycles = 3;
      for (int i = 0; i < 10; i++) begin
         z = 8'($urandom);
         c = 8'($urandom);
         push(z, c, 1'b1);
         expect_frame(z, c);
         drain($sformatf("wrap%0d", i));
      end

      // Reset mid-frame with two events still queued.
      busy_cycles = 8;
      push(8'hC1, 8'hD1, 1'b1);
      push(8'hC2, 8'hD2, 1'b1);
      push(8'hC3, 8'hD3, 1'b1);
      t = 0;
      while (rx_q.size() < 2 && t < 500) begin
         @(posedge Clock);
         #1;
         t++;
      end
      chk("midrst_timeout", (t < 500), 1);
      @(negedge Clock);
      Reset = 1'b1;
      @(posedge Clock);
      #1;
      chk("midrst_send", send, 0);
      chk("midrst_data", data, 8'h00);
      chk("midrst_busy", busy, 0);
      chk("midrst_evReady", evReady, 1);
      @(negedge Clock);
      Reset = 1'b0;
      repeat (80) @(posedge Clock);
      #1;
      chk("midrst_no_more_bytes", rx_q.size(), 2);
      chk("midrst_idle", busy, 0);
      chk("midrst_byte0", rx_q[0], 8'hA5);
      chk("midrst_byte1", rx_q[1], 8'hC1);
      $display("reset mid-frame: %0d bytes seen", rx_q.size());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
